// File: rtl/divider_pkg.sv
// Shared encodings and helpers for the restoring divider.
// DIVIDER_SIGNED_EN selects two's-complement operands (adds the FIXUP state).
package divider_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`ifndef DIVIDER_PACK
`define DIVIDER_PACK(rem, quo) {rem, quo}
`endif

// File: rtl/div_step.sv
// One restoring-division bit: shift {R,D} left, subtract b when it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] d_next
);

  logic [WIDTH+1:0] shifted;
  logic             fits;

  always_comb begin
    shifted = {r, d[WIDTH-1]};
    fits    = shifted >= (WIDTH+2)'(b);
    r_next  = (WIDTH+1)'(fits ? shifted - (WIDTH+2)'(b) : shifted);
    d_next  = {d[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/divider.sv
// Fixed-latency restoring divider, 2W/W -> {remainder, quotient}, val/rdy handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (extra FIXUP cycle).
module divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*WIDTH-1:0]   req_msg_a,
  input  logic [WIDTH-1:0]     req_msg_b,
  input  logic                 req_val,
  output logic                 req_rdy,
  output logic [2*WIDTH-1:0]   resp_msg,
  output logic                 resp_err,
  output logic                 resp_val,
  input  logic                 resp_rdy
);

  localparam int unsigned CW = clog2(WIDTH);

  logic [1:0]         state, state_n;
  logic [WIDTH:0]     r, r_n, step_r;
  logic [WIDTH-1:0]   d, d_n, step_d;
  logic [WIDTH-1:0]   b, b_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [2*WIDTH-1:0] msg_n;
  logic               err_n, val_n, rdy_n;
  logic [2*WIDTH-1:0] a_mag;
  logic [WIDTH-1:0]   b_mag;

`ifdef DIVIDER_SIGNED_EN
  logic               neg_q, neg_q_n, neg_r, neg_r_n;
  logic               q_over;
  logic [WIDTH-1:0]   quo_s, rem_s;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .d      (d),
    .b      (b),
    .r_next (step_r),
    .d_next (step_d)
  );

  // Operand magnitudes feed the unsigned datapath in either build.
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    a_mag = req_msg_a[2*WIDTH-1] ? -req_msg_a : req_msg_a;
    b_mag = req_msg_b[WIDTH-1]   ? -req_msg_b : req_msg_b;
`else
    a_mag = req_msg_a;
    b_mag = req_msg_b;
`endif
  end

  always_comb begin
    state_n = state;
    r_n     = r;
    d_n     = d;
    b_n     = b;
    cnt_n   = cnt;
    msg_n   = resp_msg;
    err_n   = resp_err;
    val_n   = resp_val;
    rdy_n   = req_rdy;
`ifdef DIVIDER_SIGNED_EN
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    q_over  = neg_q ? (d > {1'b1, {(WIDTH-1){1'b0}}}) : d[WIDTH-1];
    quo_s   = neg_q ? -d : d;
    rem_s   = neg_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];
`endif
    case (state)
      S_IDLE: begin
        if (req_val && req_rdy) begin
          cnt_n = '0;
          b_n   = b_mag;
          r_n   = {1'b0, a_mag[2*WIDTH-1:WIDTH]};
          d_n   = a_mag[WIDTH-1:0];
          rdy_n = 1'b0;
`ifdef DIVIDER_SIGNED_EN
          neg_q_n = req_msg_a[2*WIDTH-1] ^ req_msg_b[WIDTH-1];
          neg_r_n = req_msg_a[2*WIDTH-1];
`endif
          if (b_mag == '0) begin
            state_n = S_DONE;
            err_n   = 1'b1;
            val_n   = 1'b1;
            msg_n   = `DIVIDER_PACK(req_msg_a[WIDTH-1:0], {WIDTH{1'b1}});
          end else if (a_mag[2*WIDTH-1:WIDTH] >= b_mag) begin
            state_n = S_DONE;
            err_n   = 1'b1;
            val_n   = 1'b1;
            msg_n   = '0;
          end else begin
            state_n = S_CALC;
            err_n   = 1'b0;
          end
        end
      end
      S_CALC: begin
        r_n   = step_r;
        d_n   = step_d;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(WIDTH-1)) begin
`ifdef DIVIDER_SIGNED_EN
          state_n = S_FIXUP;
`else
          state_n = S_DONE;
          val_n   = 1'b1;
          msg_n   = `DIVIDER_PACK(step_r[WIDTH-1:0], step_d);
`endif
        end
      end
      S_FIXUP: begin
`ifdef DIVIDER_SIGNED_EN
        state_n = S_DONE;
        val_n   = 1'b1;
        err_n   = q_over;
        msg_n   = q_over ? '0 : `DIVIDER_PACK(rem_s, quo_s);
`else
        state_n = S_IDLE;
        rdy_n   = 1'b1;
`endif
      end
      default: begin
        if (resp_rdy) begin
          state_n = S_IDLE;
          val_n   = 1'b0;
          rdy_n   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      r        <= '0;
      d        <= '0;
      b        <= '0;
      cnt      <= '0;
      resp_msg <= '0;
      resp_err <= 1'b0;
      resp_val <= 1'b0;
      req_rdy  <= 1'b1;
`ifdef DIVIDER_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      r        <= r_n;
      d        <= d_n;
      b        <= b_n;
      cnt      <= cnt_n;
      resp_msg <= msg_n;
      resp_err <= err_n;
      resp_val <= val_n;
      req_rdy  <= rdy_n;
`ifdef DIVIDER_SIGNED_EN
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
`endif
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: model results queued at request, compared at response.
module tb_divider;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic [2*W-1:0] req_msg_a;
  logic [W-1:0]  req_msg_b;
  logic          req_val;
  logic          req_rdy;
  logic [2*W-1:0] resp_msg;
  logic          resp_err;
  logic          resp_val;
  logic          resp_rdy;

  typedef struct packed {
    logic [63:0] msg;
    logic        err;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_msg_a (req_msg_a),
    .req_msg_b (req_msg_b),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .resp_msg  (resp_msg),
    .resp_err  (resp_err),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] ma, qm, rm;
    logic [31:0] mb;
    logic        neg;
`ifdef DIVIDER_SIGNED_EN
    ma  = a[63] ? -a : a;
    mb  = b[31] ? -b : b;
    neg = a[63] ^ b[31];
    e.lat = 32'(W + 2);
`else
    ma  = a;
    mb  = b;
    neg = 1'b0;
    e.lat = 32'(W + 1);
`endif
    if (mb == 32'd0) begin
      e.msg = {a[31:0], 32'hFFFF_FFFF};
      e.err = 1'b1;
      e.lat = 32'd1;
    end else if (ma[63:32] >= mb) begin
      e.msg = 64'd0;
      e.err = 1'b1;
      e.lat = 32'd1;
    end else begin
      qm = ma / {32'd0, mb};
      rm = ma % {32'd0, mb};
`ifdef DIVIDER_SIGNED_EN
      if (qm > (neg ? 64'h8000_0000 : 64'h7FFF_FFFF)) begin
        e.msg = 64'd0;
        e.err = 1'b1;
      end else begin
        e.msg = {(a[63] ? -rm[31:0] : rm[31:0]), (neg ? -qm[31:0] : qm[31:0])};
        e.err = 1'b0;
      end
`else
      e.msg = {rm[31:0], qm[31:0]};
      e.err = neg;
`endif
    end
    return e;
  endfunction

  // Drive one request and queue its expected response; returns 1 ns after the accept edge.
  task automatic send(input logic [63:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_rdy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("req_rdy_before_send", 64'(req_rdy), 64'd1);
    req_msg_a = a;
    req_msg_b = b;
    req_val   = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    req_val   = 1'b0;
    req_msg_a = $urandom();
    req_msg_b = $urandom();
  endtask

  // Wait for resp_val (counting clocks from the accept edge) and compare with the queue head.
  task automatic wait_resp(input string tag);
    exp_t e;
    int   lat;
    e   = sb.pop_front();
    lat = 1;
    while (!resp_val && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(e.lat));
    check_eq({tag, "_msg"}, resp_msg, e.msg);
    check_eq({tag, "_err"}, 64'(resp_err), 64'(e.err));
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    resp_rdy = 1'b0;
    check_eq({tag, "_val_clr"}, 64'(resp_val), 64'd0);
    check_eq({tag, "_rdy_set"}, 64'(req_rdy), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [31:0] b);
    send(a, b);
    wait_resp(tag);
    retire(tag);
  endtask

  initial begin
    logic [63:0] held_msg;
    logic [31:0] rb, rhi;

    rst_n     = 1'b0;
    req_val   = 1'b0;
    req_msg_a = '0;
    req_msg_b = '0;
    resp_rdy  = 1'b0;
    #12;
    check_eq("rst_req_rdy", 64'(req_rdy), 64'd1);
    check_eq("rst_resp_val", 64'(resp_val), 64'd0);
    check_eq("rst_resp_err", 64'(resp_err), 64'd0);
    check_eq("rst_resp_msg", resp_msg, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("div_100_7", 64'd100, 32'd7);
    run_op("div_max", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
    run_op("div_by_zero", 64'h5, 32'd0);
    run_op("q_overflow", 64'h1_0000_0000, 32'd1);
    run_op("hi_eq_b", 64'h0000_0009_1234_5678, 32'd9);
    run_op("hi_below_b", 64'h0000_0008_FFFF_FFFF, 32'd9);
    run_op("div_by_one", 64'h0000_0000_DEAD_BEEF, 32'd1);

`ifdef DIVIDER_SIGNED_EN
    run_op("s_neg7_2", 64'hFFFF_FFFF_FFFF_FFF9, 32'd2);
    run_op("s_min_neg1", 64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF);
    run_op("s_neg_neg", 64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9);
    run_op("s_pos_neg", 64'd100, 32'hFFFF_FFF9);
`endif

    for (int i = 0; i < 12; i++) begin
      rb  = $urandom() | 32'd1;
      rhi = (i % 3 == 0) ? $urandom() : ($urandom() % rb);
      run_op($sformatf("rand%0d", i), {rhi, 32'($urandom())}, rb);
    end

    // Backpressure: response held, new requests ignored, no accept on retire edge.
    send(64'd1000, 32'd13);
    wait_resp("bp");
    held_msg = resp_msg;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_val   = 1'b1;
      req_msg_a = 64'd77;
      req_msg_b = 32'd5;
      @(posedge clk);
      #1;
      check_eq($sformatf("bp_val%0d", i), 64'(resp_val), 64'd1);
      check_eq($sformatf("bp_msg%0d", i), resp_msg, held_msg);
      check_eq($sformatf("bp_rdy%0d", i), 64'(req_rdy), 64'd0);
    end
    retire("bp");
    req_val = 1'b0;
    @(posedge clk);
    #1;
    check_eq("bp_no_accept", 64'(req_rdy), 64'd1);

    // Reset in the middle of CALC discards the operation.
    send(64'd100, 32'd7);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check_eq("mid_rst_rdy", 64'(req_rdy), 64'd1);
    check_eq("mid_rst_val", 64'(resp_val), 64'd0);
    check_eq("mid_rst_msg", resp_msg, 64'd0);
    check_eq("mid_rst_err", 64'(resp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_quiet", 64'(resp_val), 64'd0);
    run_op("after_rst", 64'd100, 32'd7);

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
